// File: rtl/sm_muldiv_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide unit.
package sm_muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdState_t;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

endpackage

// File: rtl/sm_muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// The accumulator is {upper, lower}: product/multiplier when multiplying, remainder/quotient when dividing.
module sm_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   nextAcc
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shiftedRem;
    logic [WIDTH:0] diff;

    // The remainder always stays below the divisor, so the shifted value fits in WIDTH+1 bits
    // and the borrow bit of the trial subtraction decides the quotient bit.
    always_comb begin
        sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shiftedRem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff       = shiftedRem - {1'b0, operand};
        nextAcc    = '0;
        if (isDiv) begin
            if (!diff[WIDTH])
                nextAcc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                nextAcc = {shiftedRem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            nextAcc = {sum, acc[WIDTH-1:1]};
        end else begin
            nextAcc = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sm_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO moves.
// Fixed latency of WIDTH+1 cycles from the start edge to the done pulse.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdState_t state, nextState;

    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] acc, nextAcc, prod;
    logic [WIDTH-1:0]   operand, rawA, magA, magB;
    logic [WIDTH-1:0]   fixHi, fixLo;
    logic               divMode, negMain, negRem, divZero;
    logic               isSigned, accept, isMulOp, isDivOp;

    sm_muldiv_step #(.WIDTH(WIDTH)) step (
        .isDiv   (divMode),
        .acc     (acc),
        .operand (operand),
        .nextAcc (nextAcc)
    );

    always_comb begin
        isSigned  = (op == MD_MULT) || (op == MD_DIV);
        isMulOp   = (op == MD_MULT) || (op == MD_MULTU);
        isDivOp   = (op == MD_DIV)  || (op == MD_DIVU);
        magA      = (isSigned && srcA[WIDTH-1]) ? -srcA : srcA;
        magB      = (isSigned && srcB[WIDTH-1]) ? -srcB : srcB;
        accept    = (state == IDLE) && start && !abort;
        nextState = state;
        case (state)
            IDLE: begin
                if (accept && isMulOp)
                    nextState = MUL;
                else if (accept && isDivOp)
                    nextState = DIV;
            end
            MUL, DIV: begin
                if (counter == CNT_W'(1))
                    nextState = FIX;
            end
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (abort)
            nextState = IDLE;
    end

    // Sign fix-up; min/-1 needs no special case because the magnitude quotient is already min.
    always_comb begin
        prod  = negMain ? -acc : acc;
        fixHi = prod[2*WIDTH-1:WIDTH];
        fixLo = prod[WIDTH-1:0];
        if (divMode) begin
            if (divZero) begin
                fixHi = rawA;
                fixLo = '1;
            end else begin
                fixHi = negRem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                fixLo = negMain ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            counter <= '0;
            acc     <= '0;
            operand <= '0;
            rawA    <= '0;
            divMode <= 1'b0;
            negMain <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && (isMulOp || isDivOp)) begin
                counter <= CNT_W'(WIDTH);
                divMode <= isDivOp;
                acc     <= isDivOp ? {{WIDTH{1'b0}}, magA} : {{WIDTH{1'b0}}, magB};
                operand <= isDivOp ? magB : magA;
                rawA    <= srcA;
                negMain <= isSigned && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                negRem  <= isSigned && srcA[WIDTH-1];
                divZero <= (srcB == '0);
            end else if (accept && op == MD_MTHI) begin
                hi   <= srcA;
                done <= 1'b1;
            end else if (accept && op == MD_MTLO) begin
                lo   <= srcA;
                done <= 1'b1;
            end else if ((state == MUL || state == DIV) && !abort) begin
                acc     <= nextAcc;
                counter <= counter - CNT_W'(1);
            end else if (state == FIX && !abort) begin
                hi   <= fixHi;
                lo   <= fixLo;
                done <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
